// File: rtl/rdma_rx_s2mm_cmd_gen_pkg.sv
// rtl/rdma_rx_s2mm_cmd_gen_pkg.sv - shared codes, states and helpers for the RDMA RX S2MM command generator
package rdma_rx_pkg;

  // Error codes reported on o_error_code
  localparam logic [3:0] ERR_NONE    = 4'd0;
  localparam logic [3:0] ERR_ORPHAN  = 4'd1;
  localparam logic [3:0] ERR_TRUNC   = 4'd2;
  localparam logic [3:0] ERR_OPCODE  = 4'd3;
  localparam logic [3:0] ERR_PLEN    = 4'd4;
  localparam logic [3:0] ERR_BTT     = 4'd5;
  localparam logic [3:0] ERR_ADDR    = 4'd6;
  localparam logic [3:0] ERR_KEEP    = 4'd7;
  localparam logic [3:0] ERR_LEN     = 4'd8;
  localparam logic [3:0] ERR_TUSER   = 4'd9;
  localparam logic [3:0] ERR_HDR_OVF = 4'd10;

  // Encoding is visible on o_state, so the values are fixed
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_HDR2  = 3'd3,
    ST_CHECK = 3'd4,
    ST_CMD   = 3'd5,
    ST_DATA  = 3'd6,
    ST_DROP  = 3'd7
  } state_t;

  // RDMA header layout: w0 = {qpn, flags, opcode}, w1 = address, w2 = length
  localparam int HDR_OPCODE_LSB = 0;
  localparam int HDR_LEN_BITS   = 23;
  localparam int HDR_BYTES      = 12;

  // DataMover S2MM command: {rsvd, tag, addr, drr, eof, dsa, type, btt}
  function automatic logic [71:0] pack_s2mm_cmd(input logic [3:0]  tag,
                                                input logic [31:0] addr,
                                                input logic [22:0] btt);
    return {4'h0, tag, addr, 1'b0, 1'b1, 6'h00, 1'b1, btt};
  endfunction

  // Number of valid bytes in a 32-bit beat
  function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
    return {2'b00, keep[0]} + {2'b00, keep[1]} + {2'b00, keep[2]} + {2'b00, keep[3]};
  endfunction

endpackage

// File: rtl/rdma_rx_s2mm_cmd_gen_if.sv
// rtl/rdma_rx_s2mm_cmd_gen_if.sv - header, payload, command and data bundle of the RDMA RX S2MM command generator
interface rdma_rx_s2mm_cmd_gen_if;

  logic        i_hdr_valid;
  logic [15:0] i_hdr_payload_len;
  logic [31:0] i_hdr_src_ip;
  logic [15:0] i_hdr_src_port;

  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        s_axis_tready;

  logic [71:0] m_cmd_tdata;
  logic        m_cmd_tvalid;
  logic        m_cmd_tready;

  logic [31:0] m_data_tdata;
  logic [3:0]  m_data_tkeep;
  logic        m_data_tvalid;
  logic        m_data_tlast;
  logic        m_data_tready;

  logic        o_done;
  logic        o_error;
  logic [3:0]  o_error_code;
  logic [31:0] o_last_src_ip;
  logic [15:0] o_last_src_port;
  logic [2:0]  o_state;

  // View of the command generator itself
  modport slave (
    input  i_hdr_valid, i_hdr_payload_len, i_hdr_src_ip, i_hdr_src_port,
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output s_axis_tready,
    output m_cmd_tdata, m_cmd_tvalid,
    input  m_cmd_tready,
    output m_data_tdata, m_data_tkeep, m_data_tvalid, m_data_tlast,
    input  m_data_tready,
    output o_done, o_error, o_error_code, o_last_src_ip, o_last_src_port, o_state
  );

  // View of the surroundings: decapsulator, DataMover and status sink
  modport master (
    output i_hdr_valid, i_hdr_payload_len, i_hdr_src_ip, i_hdr_src_port,
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  s_axis_tready,
    input  m_cmd_tdata, m_cmd_tvalid,
    output m_cmd_tready,
    input  m_data_tdata, m_data_tkeep, m_data_tvalid, m_data_tlast,
    output m_data_tready,
    input  o_done, o_error, o_error_code, o_last_src_ip, o_last_src_port, o_state
  );

endinterface

// File: rtl/rdma_rx_s2mm_cmd_gen_hdr_slot.sv
// rtl/rdma_rx_s2mm_cmd_gen_hdr_slot.sv - one-deep validated-header register with full flag and overflow detect
module rdma_rx_hdr_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        hdr_valid,
  input  logic [15:0] hdr_payload_len,
  input  logic [31:0] hdr_src_ip,
  input  logic [15:0] hdr_src_port,
  input  logic        free_slot,
  output logic        full,
  output logic [15:0] payload_len,
  output logic [31:0] src_ip,
  output logic [15:0] src_port,
  output logic        overflow
);

  // A pulse landing in the same cycle the slot frees is a legal capture, not an overflow
  assign overflow = hdr_valid & full & ~free_slot;

  // Capture on a pulse when there is room; otherwise keep the old header untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      full        <= 1'b0;
      payload_len <= '0;
      src_ip      <= '0;
      src_port    <= '0;
    end else if (hdr_valid && !overflow) begin
      full        <= 1'b1;
      payload_len <= hdr_payload_len;
      src_ip      <= hdr_src_ip;
      src_port    <= hdr_src_port;
    end else if (free_slot) begin
      full        <= 1'b0;
    end
  end

endmodule

// File: rtl/rdma_rx_s2mm_cmd_gen.sv
// rtl/rdma_rx_s2mm_cmd_gen.sv - parses the RDMA header of each UDP payload and issues one DataMover S2MM command
module rdma_rx_s2mm_cmd_gen #(
  parameter logic [7:0]  RDMA_OP_WRITE = 8'h01,
  parameter logic [22:0] MAX_BTT       = 23'h7FFFFF,
  parameter logic [31:0] ADDR_BASE     = 32'h1000_0000,
  parameter logic [31:0] ADDR_SIZE     = 32'h0100_0000
) (
  input logic                       iClk,
  input logic                       iRst,
  rdma_rx_s2mm_cmd_gen_if.slave     bus
);

  import rdma_rx_pkg::*;

  state_t      state;
  logic [7:0]  opcode;
  logic [31:0] addr;
  logic [22:0] len;
  logic [23:0] byte_cnt;
  logic [23:0] byte_total;
  logic [3:0]  tag;
  logic [71:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        done;
  logic        error;
  logic [3:0]  error_code;
  logic [31:0] last_ip;
  logic [15:0] last_port;

  logic        in_tready;
  logic        in_accept;
  logic        slot_full;
  logic        slot_ovf;
  logic        slot_free;
  logic [15:0] slot_len;
  logic [31:0] slot_ip;
  logic [15:0] slot_port;
  logic [3:0]  check_code;
  logic [32:0] end_addr;
  logic [32:0] win_end;

  rdma_rx_hdr_slot u_hdr_slot (
    .clk             (iClk),
    .rst             (iRst),
    .hdr_valid       (bus.i_hdr_valid),
    .hdr_payload_len (bus.i_hdr_payload_len),
    .hdr_src_ip      (bus.i_hdr_src_ip),
    .hdr_src_port    (bus.i_hdr_src_port),
    .free_slot       (slot_free),
    .full            (slot_full),
    .payload_len     (slot_len),
    .src_ip          (slot_ip),
    .src_port        (slot_port),
    .overflow        (slot_ovf)
  );

  // Payload is pulled while parsing or draining, and follows the DataMover while forwarding
  always_comb begin
    in_tready = 1'b0;
    case (state)
      ST_HDR0, ST_HDR1, ST_HDR2, ST_DROP: in_tready = 1'b1;
      ST_DATA:                            in_tready = bus.m_data_tready;
      default:                            in_tready = 1'b0;
    endcase
  end

  assign in_accept  = bus.s_axis_tvalid & in_tready;
  // Every accepted tlast returns the FSM to IDLE, which is exactly when the slot frees
  assign slot_free  = in_accept & bus.s_axis_tlast;
  assign byte_total = byte_cnt + {21'd0, keep_bytes(bus.s_axis_tkeep)};

  // 33-bit sums so a high address plus length cannot wrap past the window check
  assign end_addr = {1'b0, addr} + {10'd0, len};
  assign win_end  = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

  // Header checks in priority order; the first failure names the error
  always_comb begin
    check_code = ERR_NONE;
    if (opcode != RDMA_OP_WRITE) begin
      check_code = ERR_OPCODE;
    end else if ({8'd0, slot_len} != ({1'b0, len} + 24'(HDR_BYTES))) begin
      check_code = ERR_PLEN;
    end else if ((len == '0) || ({1'b0, len} > {1'b0, MAX_BTT})) begin
      check_code = ERR_BTT;
    end else if (({1'b0, addr} < {1'b0, ADDR_BASE}) || (end_addr > win_end)) begin
      check_code = ERR_ADDR;
    end
  end

  // Main packet FSM with registered command, status and error outputs
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= ST_IDLE;
      opcode     <= '0;
      addr       <= '0;
      len        <= '0;
      byte_cnt   <= '0;
      tag        <= '0;
      cmd_tdata  <= '0;
      cmd_tvalid <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      error_code <= ERR_NONE;
      last_ip    <= '0;
      last_port  <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (slot_full || bus.i_hdr_valid) begin
            state <= ST_HDR0;
          end else if (bus.s_axis_tvalid) begin
            state      <= ST_DROP;
            error      <= 1'b1;
            error_code <= ERR_ORPHAN;
          end
        end
        ST_HDR0, ST_HDR1, ST_HDR2: begin
          if (in_accept) begin
            if (bus.s_axis_tlast) begin
              state      <= ST_IDLE;
              error      <= 1'b1;
              error_code <= ERR_TRUNC;
            end else if (bus.s_axis_tkeep != 4'hF) begin
              state      <= ST_DROP;
              error      <= 1'b1;
              error_code <= ERR_KEEP;
            end else if (state == ST_HDR0) begin
              opcode <= bus.s_axis_tdata[HDR_OPCODE_LSB +: 8];
              state  <= ST_HDR1;
            end else if (state == ST_HDR1) begin
              addr  <= bus.s_axis_tdata;
              state <= ST_HDR2;
            end else begin
              len   <= bus.s_axis_tdata[HDR_LEN_BITS-1:0];
              state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (check_code != ERR_NONE) begin
            state      <= ST_DROP;
            error      <= 1'b1;
            error_code <= check_code;
          end else begin
            cmd_tdata  <= pack_s2mm_cmd(tag, addr, len);
            cmd_tvalid <= 1'b1;
            byte_cnt   <= '0;
            state      <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (bus.m_cmd_tready) begin
            cmd_tvalid <= 1'b0;
            tag        <= tag + 4'd1;
            state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (in_accept) begin
            byte_cnt <= byte_total;
            if (bus.s_axis_tlast) begin
              state <= ST_IDLE;
              if (byte_total != {1'b0, len}) begin
                error      <= 1'b1;
                error_code <= ERR_LEN;
              end else if (bus.s_axis_tuser) begin
                error      <= 1'b1;
                error_code <= ERR_TUSER;
              end else begin
                done      <= 1'b1;
                last_ip   <= slot_ip;
                last_port <= slot_port;
              end
            end
          end
        end
        ST_DROP: begin
          if (in_accept && bus.s_axis_tlast) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Header overflow outranks any packet error raised in the same cycle
      if (slot_ovf) begin
        error      <= 1'b1;
        error_code <= ERR_HDR_OVF;
      end
    end
  end

  assign bus.s_axis_tready   = in_tready;
  assign bus.m_cmd_tdata     = cmd_tdata;
  assign bus.m_cmd_tvalid    = cmd_tvalid;
  assign bus.m_data_tdata    = bus.s_axis_tdata;
  assign bus.m_data_tkeep    = bus.s_axis_tkeep;
  assign bus.m_data_tlast    = bus.s_axis_tlast;
  assign bus.m_data_tvalid   = (state == ST_DATA) & bus.s_axis_tvalid;
  assign bus.o_done          = done;
  assign bus.o_error         = error;
  assign bus.o_error_code    = error_code;
  assign bus.o_last_src_ip   = last_ip;
  assign bus.o_last_src_port = last_port;
  assign bus.o_state         = state;

endmodule

// File: tb/tb_rdma_rx_s2mm_cmd_gen.sv
// tb/tb_rdma_rx_s2mm_cmd_gen.sv - directed self-checking bench for the RDMA RX S2MM command generator
module tb_rdma_rx_s2mm_cmd_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rdma_rx_s2mm_cmd_gen_if bus();

  rdma_rx_s2mm_cmd_gen dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  int          n_cmd    = 0;
  int          n_done   = 0;
  int          n_err    = 0;
  logic [71:0] last_cmd = '0;
  logic [3:0]  last_err = '0;
  logic [31:0] data_q[$];
  bit          toggle_en = 1'b0;

  // Record transfers and pulses between clock edges
  always @(negedge clk) begin
    if (bus.m_data_tvalid && bus.m_data_tready) data_q.push_back(bus.m_data_tdata);
    if (bus.m_cmd_tvalid && bus.m_cmd_tready) begin
      n_cmd    <= n_cmd + 1;
      last_cmd <= bus.m_cmd_tdata;
    end
    if (bus.o_done) n_done <= n_done + 1;
    if (bus.o_error) begin
      n_err    <= n_err + 1;
      last_err <= bus.o_error_code;
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_hdr(input logic [15:0] plen, input logic [31:0] ip, input logic [15:0] port);
    bus.i_hdr_payload_len = plen;
    bus.i_hdr_src_ip      = ip;
    bus.i_hdr_src_port    = port;
    bus.i_hdr_valid       = 1'b1;
    @(posedge clk);
    #1;
    bus.i_hdr_valid       = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    bit ok;
    ok = 1'b0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = k;
    bus.s_axis_tlast  = l;
    bus.s_axis_tuser  = u;
    bus.s_axis_tvalid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (bus.s_axis_tready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (toggle_en) bus.m_data_tready = ~bus.m_data_tready;
    end
    bus.s_axis_tvalid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL beat_accept data=%h got=not_accepted exp=accepted", d);
    end
  endtask

  task automatic send_rdma_hdr(input logic [7:0] op, input logic [31:0] a, input logic [31:0] l);
    send_beat({24'h0, op}, 4'hF, 1'b0, 1'b0);
    send_beat(a, 4'hF, 1'b0, 1'b0);
    send_beat(l, 4'hF, 1'b0, 1'b0);
  endtask

  task automatic send_data(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) send_beat(base + 32'(i), 4'hF, (i == n - 1), 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.i_hdr_valid = 1'b0; bus.i_hdr_payload_len = '0; bus.i_hdr_src_ip = '0; bus.i_hdr_src_port = '0;
    bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0; bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0; bus.s_axis_tuser = 1'b0;
    bus.m_cmd_tready = 1'b1; bus.m_data_tready = 1'b1;
    idle_cycles(3);
    checks++; if (bus.o_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.o_state); end
    checks++; if (bus.m_cmd_tvalid !== 1'b0) begin failures++; $display("FAIL reset_cmd_tvalid got=%b exp=0", bus.m_cmd_tvalid); end
    checks++; if (bus.m_data_tvalid !== 1'b0) begin failures++; $display("FAIL reset_data_tvalid got=%b exp=0", bus.m_data_tvalid); end
    checks++; if (bus.s_axis_tready !== 1'b0) begin failures++; $display("FAIL reset_s_tready got=%b exp=0", bus.s_axis_tready); end
    checks++; if (bus.o_error_code !== 4'd0) begin failures++; $display("FAIL reset_error_code got=%0d exp=0", bus.o_error_code); end
    checks++; if (bus.o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.o_done); end
    checks++; if (bus.o_last_src_ip !== 32'h0) begin failures++; $display("FAIL reset_last_ip got=%h exp=0", bus.o_last_src_ip); end
    rst = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_good_write;
    int c0, d0;
    c0 = n_cmd; d0 = n_done;
    data_q.delete();
    send_hdr(16'd28, 32'hC0A8_0001, 16'd4791);
    send_rdma_hdr(8'h01, 32'h1000_0040, 32'h0000_0010);
    @(negedge clk);
    checks++; if (bus.o_state !== 3'd4) begin failures++; $display("FAIL good_check_state got=%0d exp=4", bus.o_state); end
    checks++; if (bus.m_cmd_tvalid !== 1'b0) begin failures++; $display("FAIL good_cmd_early got=%b exp=0", bus.m_cmd_tvalid); end
    @(negedge clk);
    checks++; if (bus.m_cmd_tvalid !== 1'b1) begin failures++; $display("FAIL good_cmd_latency got=%b exp=1", bus.m_cmd_tvalid); end
    checks++; if (bus.m_cmd_tdata !== 72'h00_1000_0040_4080_0010) begin failures++; $display("FAIL good_cmd_tdata got=%h exp=%h", bus.m_cmd_tdata, 72'h00_1000_0040_4080_0010); end
    @(posedge clk);
    #1;
    send_data(4, 32'hA000_0000);
    idle_cycles(2);
    checks++; if (data_q.size() != 4) begin failures++; $display("FAIL good_beats got=%0d exp=4", data_q.size()); end
    for (int i = 0; i < data_q.size() && i < 4; i++) begin
      checks++; if (data_q[i] !== 32'hA000_0000 + 32'(i)) begin failures++; $display("FAIL good_data%0d got=%h exp=%h", i, data_q[i], 32'hA000_0000 + 32'(i)); end
    end
    checks++; if (n_done != d0 + 1) begin failures++; $display("FAIL good_done got=%0d exp=%0d", n_done - d0, 1); end
    checks++; if (n_cmd != c0 + 1) begin failures++; $display("FAIL good_cmd_count got=%0d exp=1", n_cmd - c0); end
    checks++; if (bus.o_last_src_ip !== 32'hC0A8_0001) begin failures++; $display("FAIL good_last_ip got=%h exp=c0a80001", bus.o_last_src_ip); end
    checks++; if (bus.o_last_src_port !== 16'd4791) begin failures++; $display("FAIL good_last_port got=%0d exp=4791", bus.o_last_src_port); end
    checks++; if (bus.o_state !== 3'd0) begin failures++; $display("FAIL good_end_state got=%0d exp=0", bus.o_state); end
  endtask

  task automatic test_bad_opcode;
    int c0, e0;
    c0 = n_cmd; e0 = n_err;
    data_q.delete();
    send_hdr(16'd28, 32'h0A00_0002, 16'd100);
    send_rdma_hdr(8'h02, 32'h1000_0040, 32'h0000_0010);
    send_data(4, 32'hB000_0000);
    idle_cycles(2);
    checks++; if (last_err !== 4'd3) begin failures++; $display("FAIL opcode_err_code got=%0d exp=3", last_err); end
    checks++; if (n_err != e0 + 1) begin failures++; $display("FAIL opcode_err_count got=%0d exp=1", n_err - e0); end
    checks++; if (n_cmd != c0) begin failures++; $display("FAIL opcode_no_cmd got=%0d exp=0", n_cmd - c0); end
    checks++; if (data_q.size() != 0) begin failures++; $display("FAIL opcode_no_data got=%0d exp=0", data_q.size()); end
    checks++; if (bus.o_state !== 3'd0) begin failures++; $display("FAIL opcode_end_state got=%0d exp=0", bus.o_state); end
  endtask

  task automatic test_orphan;
    int e0;
    e0 = n_err;
    data_q.delete();
    send_data(2, 32'hC000_0000);
    idle_cycles(2);
    checks++; if (last_err !== 4'd1) begin failures++; $display("FAIL orphan_err_code got=%0d exp=1", last_err); end
    checks++; if (n_err != e0 + 1) begin failures++; $display("FAIL orphan_err_count got=%0d exp=1", n_err - e0); end
    checks++; if (data_q.size() != 0) begin failures++; $display("FAIL orphan_no_data got=%0d exp=0", data_q.size()); end
    checks++; if (bus.o_state !== 3'd0) begin failures++; $display("FAIL orphan_end_state got=%0d exp=0", bus.o_state); end
  endtask

  task automatic test_addr_range;
    int c0;
    c0 = n_cmd;
    send_hdr(16'd28, 32'h0A00_0003, 16'd101);
    send_rdma_hdr(8'h01, 32'h10FF_FFF8, 32'h0000_0010);
    send_data(4, 32'hD000_0000);
    idle_cycles(2);
    checks++; if (last_err !== 4'd6) begin failures++; $display("FAIL addr_err_code got=%0d exp=6", last_err); end
    checks++; if (n_cmd != c0) begin failures++; $display("FAIL addr_no_cmd got=%0d exp=0", n_cmd - c0); end
  endtask

  task automatic test_trunc;
    int c0;
    c0 = n_cmd;
    send_hdr(16'd28, 32'h0A00_0004, 16'd102);
    send_beat(32'h0000_0001, 4'hF, 1'b1, 1'b0);
    idle_cycles(2);
    checks++; if (last_err !== 4'd2) begin failures++; $display("FAIL trunc_err_code got=%0d exp=2", last_err); end
    checks++; if (bus.o_state !== 3'd0) begin failures++; $display("FAIL trunc_end_state got=%0d exp=0", bus.o_state); end
    checks++; if (n_cmd != c0) begin failures++; $display("FAIL trunc_no_cmd got=%0d exp=0", n_cmd - c0); end
  endtask

  task automatic test_hdr_overflow;
    int d0, e0;
    d0 = n_done; e0 = n_err;
    send_hdr(16'd28, 32'h0A00_0005, 16'd200);
    send_hdr(16'd40, 32'h0A00_0006, 16'd300);
    send_rdma_hdr(8'h01, 32'h1000_0080, 32'h0000_0010);
    send_data(4, 32'hE000_0000);
    idle_cycles(2);
    checks++; if (last_err !== 4'd10) begin failures++; $display("FAIL ovf_err_code got=%0d exp=10", last_err); end
    checks++; if (n_err != e0 + 1) begin failures++; $display("FAIL ovf_err_count got=%0d exp=1", n_err - e0); end
    checks++; if (n_done != d0 + 1) begin failures++; $display("FAIL ovf_done got=%0d exp=1", n_done - d0); end
    checks++; if (bus.o_last_src_ip !== 32'h0A00_0005) begin failures++; $display("FAIL ovf_kept_ip got=%h exp=0a000005", bus.o_last_src_ip); end
  endtask

  task automatic test_backpressure;
    int c0, d0;
    c0 = n_cmd; d0 = n_done;
    data_q.delete();
    bus.m_cmd_tready = 1'b0;
    send_hdr(16'd28, 32'h0A00_0007, 16'd400);
    send_rdma_hdr(8'h01, 32'h1000_0100, 32'h0000_0010);
    bus.s_axis_tdata = 32'hF000_0000; bus.s_axis_tkeep = 4'hF; bus.s_axis_tlast = 1'b0; bus.s_axis_tvalid = 1'b1;
    idle_cycles(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.m_cmd_tvalid !== 1'b1) begin failures++; $display("FAIL bp_cmd_hold%0d got=%b exp=1", i, bus.m_cmd_tvalid); end
      checks++; if (bus.m_cmd_tdata !== 72'h02_1000_0100_4080_0010) begin failures++; $display("FAIL bp_cmd_tdata%0d got=%h exp=%h", i, bus.m_cmd_tdata, 72'h02_1000_0100_4080_0010); end
      checks++; if (bus.s_axis_tready !== 1'b0) begin failures++; $display("FAIL bp_s_tready%0d got=%b exp=0", i, bus.s_axis_tready); end
      checks++; if (bus.m_data_tvalid !== 1'b0) begin failures++; $display("FAIL bp_data_early%0d got=%b exp=0", i, bus.m_data_tvalid); end
      @(posedge clk);
      #1;
    end
    bus.m_cmd_tready = 1'b1;
    toggle_en = 1'b1;
    send_data(4, 32'hF000_0000);
    toggle_en = 1'b0;
    bus.m_data_tready = 1'b1;
    idle_cycles(2);
    checks++; if (data_q.size() != 4) begin failures++; $display("FAIL bp_beats got=%0d exp=4", data_q.size()); end
    for (int i = 0; i < data_q.size() && i < 4; i++) begin
      checks++; if (data_q[i] !== 32'hF000_0000 + 32'(i)) begin failures++; $display("FAIL bp_data%0d got=%h exp=%h", i, data_q[i], 32'hF000_0000 + 32'(i)); end
    end
    checks++; if (n_cmd != c0 + 1) begin failures++; $display("FAIL bp_cmd_count got=%0d exp=1", n_cmd - c0); end
    checks++; if (n_done != d0 + 1) begin failures++; $display("FAIL bp_done got=%0d exp=1", n_done - d0); end
  endtask

  task automatic test_short_data;
    int c0, d0;
    c0 = n_cmd; d0 = n_done;
    data_q.delete();
    send_hdr(16'd28, 32'h0A00_0008, 16'd500);
    send_rdma_hdr(8'h01, 32'h1000_0200, 32'h0000_0010);
    send_data(3, 32'h1234_0000);
    idle_cycles(2);
    checks++; if (last_err !== 4'd8) begin failures++; $display("FAIL short_err_code got=%0d exp=8", last_err); end
    checks++; if (n_done != d0) begin failures++; $display("FAIL short_no_done got=%0d exp=0", n_done - d0); end
    checks++; if (data_q.size() != 3) begin failures++; $display("FAIL short_beats got=%0d exp=3", data_q.size()); end
    checks++; if (n_cmd != c0 + 1) begin failures++; $display("FAIL short_cmd_count got=%0d exp=1", n_cmd - c0); end
  endtask

  task automatic test_tag_wrap;
    int d0;
    logic [31:0] a;
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(1);
    d0 = n_done;
    for (int i = 0; i < 17; i++) begin
      a = (i == 16) ? 32'h10FF_FFF0 : 32'h1000_0000 + 32'(i) * 32'h20;
      send_hdr(16'd28, 32'h0B00_0000 + 32'(i), 16'd600);
      send_rdma_hdr(8'h01, a, 32'h0000_0010);
      send_data(4, 32'h5500_0000 + 32'(i) * 32'h10);
      idle_cycles(1);
      if (i == 0) begin
        checks++; if (last_cmd[67:64] !== 4'd0) begin failures++; $display("FAIL wrap_tag_first got=%0d exp=0", last_cmd[67:64]); end
      end
      if (i == 15) begin
        checks++; if (last_cmd[67:64] !== 4'd15) begin failures++; $display("FAIL wrap_tag_16th got=%0d exp=15", last_cmd[67:64]); end
      end
      if (i == 16) begin
        checks++; if (last_cmd[67:64] !== 4'd0) begin failures++; $display("FAIL wrap_tag_17th got=%0d exp=0", last_cmd[67:64]); end
        checks++; if (last_cmd[63:32] !== 32'h10FF_FFF0) begin failures++; $display("FAIL wrap_edge_addr got=%h exp=10fffff0", last_cmd[63:32]); end
      end
    end
    idle_cycles(1);
    checks++; if (n_done != d0 + 17) begin failures++; $display("FAIL wrap_done_count got=%0d exp=17", n_done - d0); end
    checks++; if (bus.o_last_src_ip !== 32'h0B00_0010) begin failures++; $display("FAIL wrap_last_ip got=%h exp=0b000010", bus.o_last_src_ip); end
  endtask

  initial begin
    test_reset();
    test_good_write();
    test_bad_opcode();
    test_orphan();
    test_addr_range();
    test_trunc();
    test_hdr_overflow();
    test_backpressure();
    test_short_data();
    test_tag_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
